// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared Q8.8 constants and dot-product feeder FSM state type
package nn_pkg;

  localparam int          Q_FRAC = 8;
  localparam logic [15:0] Q_MAX  = 16'h7FFF;
  localparam logic [15:0] Q_MIN  = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    CAPTURE
  } feeder_state_t;

endpackage

// File: rtl/q88_mul_sat.sv
// rtl/q88_mul_sat.sv - registered signed Q8.8 multiply with truncate/saturate back to Q8.8
module q88_mul_sat
  import nn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] w,
  input  logic [15:0] x,
  output logic        out_valid,
  output logic [15:0] out_data
);

  logic signed [31:0] w_ext;
  logic signed [31:0] x_ext;
  logic signed [31:0] prod;
  logic               prod_valid;
  logic               overflow;
  logic               unused_frac;

  assign w_ext = {{16{w[15]}}, w};
  assign x_ext = {{16{x[15]}}, x};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid) prod <= w_ext * x_ext;
    end
  end

  // Saturation works straight off the product register so a term reaches the
  // accumulator one cycle after its operands arrive.
  assign overflow = !((&prod[31:23]) || !(|prod[31:23]));

  always_comb begin
    out_data = prod[Q_FRAC+15:Q_FRAC];
    if (overflow) out_data = prod[31] ? Q_MIN : Q_MAX;
  end

  assign out_valid   = prod_valid;
  assign unused_frac = ^prod[Q_FRAC-1:0];

endmodule

// File: rtl/accum_feeder.sv
// rtl/accum_feeder.sv - dot-product sequencer feeding one NN accumulator
// Build option: define ACCUM_FEEDER_RELU_EN to clamp negative results to zero.
module accum_feeder
  import nn_pkg::*;
#(
  parameter int LEN = 16,
  parameter int AW  = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   bias,
  output logic          busy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   w_data,
  input  logic [15:0]   x_data,
  output logic          acc_clr,
  output logic [15:0]   acc_load,
  output logic [15:0]   acc_din,
  output logic          acc_enable,
  input  logic [15:0]   acc_dout,
  input  logic          acc_valid,
  output logic [15:0]   res,
  output logic          res_valid
);

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  feeder_state_t state;
  feeder_state_t state_next;
  logic [AW-1:0] addr;
  logic [AW-1:0] vcnt;
  logic [AW-1:0] vcnt_next;
  logic [15:0]   bias_q;
  logic          rd_valid;
  logic          counting;
  logic          capture;
  logic [15:0]   res_next;

  // CAPTURE holds while the final term is still outstanding; its acc_valid
  // ends the job so the following cycle is already IDLE.
  assign counting  = acc_valid && (state == FETCH || state == DRAIN);
  assign vcnt_next = vcnt + AW'(counting);
  assign capture   = (state == CAPTURE) && acc_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    rd_en      = 1'b0;
    acc_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        acc_clr = (addr == '0);
        if (addr == LAST) state_next = (vcnt_next == LAST) ? CAPTURE : DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (vcnt_next == LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (acc_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ACCUM_FEEDER_RELU_EN
  assign res_next = acc_dout[15] ? 16'h0000 : acc_dout;
`else
  assign res_next = acc_dout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      vcnt      <= '0;
      bias_q    <= '0;
      rd_valid  <= 1'b0;
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      res_valid <= 1'b0;
      if (state == IDLE && start) bias_q <= bias;
      if (state == FETCH) addr <= (addr == LAST) ? '0 : addr + AW'(1);
      if (capture) begin
        vcnt      <= '0;
        res       <= res_next;
        res_valid <= 1'b1;
      end else begin
        vcnt <= vcnt_next;
      end
    end
  end

  assign rd_addr  = addr;
  assign acc_load = bias_q;

  q88_mul_sat u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_valid),
    .w         (w_data),
    .x         (x_data),
    .out_valid (acc_enable),
    .out_data  (acc_din)
  );

endmodule

// File: tb/tb_accum_feeder.sv
// tb/tb_accum_feeder.sv - self-checking bench for accum_feeder (LEN=4 and LEN=1 instances)
module tb_accum_feeder;

  localparam int LEN = 4;

  typedef struct packed {
    logic [15:0]      bias;
    logic [3:0][15:0] w;
    logic [3:0][15:0] x;
    logic [15:0]      exp_res;
  } vec_t;

  typedef struct {
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LEN=4 instance with operand memory and accumulator models
  logic        start = 1'b0;
  logic [15:0] bias = 16'h0000;
  logic        busy, rd_en, acc_clr, acc_enable, acc_valid, res_valid;
  logic [1:0]  rd_addr;
  logic [15:0] w_data, x_data, acc_load, acc_din, acc_dout, res;
  logic [15:0] wmem [4];
  logic [15:0] xmem [4];
  logic [15:0] acc;
  logic        acc_valid_r;
  logic        inj = 1'b0;

  assign acc_dout  = acc;
  assign acc_valid = acc_valid_r | inj;

  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= wmem[rd_addr];
      x_data <= xmem[rd_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      acc         <= 16'h0000;
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= acc_enable;
      if (acc_clr) acc <= acc_load;
      else if (acc_enable) acc <= acc + acc_din;
    end
  end

  accum_feeder #(.LEN(LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .w_data(w_data), .x_data(x_data),
    .acc_clr(acc_clr), .acc_load(acc_load), .acc_din(acc_din),
    .acc_enable(acc_enable), .acc_dout(acc_dout), .acc_valid(acc_valid),
    .res(res), .res_valid(res_valid)
  );

  // LEN=1 instance
  logic        start1 = 1'b0;
  logic [15:0] bias1 = 16'h0000;
  logic        busy1, rd_en1, acc_clr1, acc_enable1, acc_valid1, res_valid1;
  logic [0:0]  rd_addr1;
  logic [15:0] w1_data, x1_data, acc_load1, acc_din1, acc_dout1, res1;
  logic [15:0] w1mem = 16'h0000;
  logic [15:0] x1mem = 16'h0000;

  always @(posedge clk) begin
    if (rd_en1) begin
      w1_data <= w1mem;
      x1_data <= x1mem;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      acc_dout1  <= 16'h0000;
      acc_valid1 <= 1'b0;
    end else begin
      acc_valid1 <= acc_enable1;
      if (acc_clr1) acc_dout1 <= acc_load1;
      else if (acc_enable1) acc_dout1 <= acc_dout1 + acc_din1;
    end
  end

  accum_feeder #(.LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bias(bias1), .busy(busy1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .w_data(w1_data), .x_data(x1_data),
    .acc_clr(acc_clr1), .acc_load(acc_load1), .acc_din(acc_din1),
    .acc_enable(acc_enable1), .acc_dout(acc_dout1), .acc_valid(acc_valid1),
    .res(res1), .res_valid(res_valid1)
  );

  ev_t clr_q[$];
  ev_t din_q[$];
  ev_t res_q[$];
  ev_t mon_ev;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic extra(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected strobe at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int qmul(input logic [15:0] w, input logic [15:0] x);
    shortint sw;
    shortint sx;
    longint  p;
    sw = w;
    sx = x;
    p  = longint'(sw) * longint'(sx);
    p  = p >>> 8;
    if (p > 32767) return 32'h7FFF;
    if (p < -32768) return 32'h8000;
    return int'(p) & 32'hFFFF;
  endfunction

  function automatic int exp_res(input logic [15:0] r);
`ifdef ACCUM_FEEDER_RELU_EN
    return r[15] ? 0 : int'(r);
`else
    return int'(r);
`endif
  endfunction

  task automatic start_job(input vec_t v, input int nterms, input bit want_res);
    for (int k = 0; k < LEN; k++) begin
      wmem[k] = v.w[k];
      xmem[k] = v.x[k];
    end
    start = 1'b1;
    bias  = v.bias;
    clr_q.push_back('{int'(v.bias), cyc + 1});
    for (int k = 0; k < nterms; k++) din_q.push_back('{qmul(v.w[k], v.x[k]), cyc + 3 + k});
    if (want_res) res_q.push_back('{exp_res(v.exp_res), cyc + LEN + 4});
  endtask

  always @(negedge clk) begin
    if (acc_clr) begin
      if (clr_q.size() == 0) extra("clr_extra");
      else begin
        mon_ev = clr_q.pop_front();
        check("clr_cycle", cyc, mon_ev.cyc);
        check("clr_load", int'(acc_load), mon_ev.val);
      end
    end
    if (acc_enable) begin
      if (din_q.size() == 0) extra("din_extra");
      else begin
        mon_ev = din_q.pop_front();
        check("din_cycle", cyc, mon_ev.cyc);
        check("din_value", int'(acc_din), mon_ev.val);
      end
    end
    if (res_valid) begin
      if (res_q.size() == 0) extra("res_extra");
      else begin
        mon_ev = res_q.pop_front();
        check("res_cycle", cyc, mon_ev.cyc);
        check("res_value", int'(res), mon_ev.val);
      end
    end
  end

  initial begin
    vec_t vecs[6];
    // packed w/x lists are written term 3 first, term 0 last
    vecs[0] = '{16'h0100, {16'h0100, 16'h0100, 16'h0100, 16'h0100},
                {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 16'h0B00};
    vecs[1] = '{16'h0000, {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF},
                {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 16'hFFFF};
    vecs[2] = '{16'hF000, {16'h0100, 16'h0100, 16'h0100, 16'h0100},
                {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hF000};
    vecs[3] = '{16'h0000, {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00},
                {16'h0040, 16'h0080, 16'h0100, 16'h0200}, 16'hFC40};
    vecs[4] = '{16'h7000, {16'h0100, 16'h0100, 16'h0100, 16'h0100},
                {16'h0000, 16'h0000, 16'h1000, 16'h1000}, 16'h9000};
    vecs[5] = '{16'h0000, {16'h0180, 16'h0180, 16'h0180, 16'h0180},
                {16'hFFFD, 16'h0003, 16'hFFFD, 16'h0003}, 16'hFFFE};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ctrl", int'({busy, rd_en, rd_addr, acc_clr, acc_enable, res_valid}), 0);
    check("rst_load", int'(acc_load), 0);
    check("rst_din", int'(acc_din), 0);
    check("rst_res", int'(res), 0);
    check("rst1_outs", int'({busy1, rd_en1, rd_addr1, acc_clr1, acc_enable1, res_valid1, res1}), 0);
    step();
    rst = 1'b0;

    // stray acc_valid while idle must not be counted
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step();
      start_job(vecs[i], LEN, 1'b1);
      @(negedge clk);
      check("busy_at_accept", busy, 0);
      for (int s = 1; s <= LEN + 3; s++) begin
        step();
        start = 1'b0;
        if (i == 0 && s == 2) begin
          start = 1'b1;
          bias  = 16'h0500;
        end
        @(negedge clk);
        check("busy", busy, 1);
        if (i == 0 && s == 4) check("bias_held", int'(acc_load), 16'h0100);
      end
    end

    // reset in cycle 4 of a job: only terms 0 and 1 reach the accumulator
    step();
    start_job(vecs[0], 2, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl", int'({busy, rd_en, rd_addr, acc_clr, acc_enable, res_valid}), 0);
    check("mid_rst_load", int'(acc_load), 0);
    check("mid_rst_din", int'(acc_din), 0);
    check("mid_rst_res", int'(res), 0);
    repeat (3) step();
    start_job(vecs[0], LEN, 1'b1);
    for (int s = 1; s <= LEN + 4; s++) begin
      step();
      start = 1'b0;
    end

    // LEN=1 instance: read in cycle 1, term in cycle 3, result in cycle 5
    step();
    w1mem  = 16'h0200;
    x1mem  = 16'h0300;
    bias1  = 16'h0080;
    start1 = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      step();
      start1 = 1'b0;
      @(negedge clk);
      check("l1_rd_en", rd_en1, int'(s == 1));
      check("l1_clr", acc_clr1, int'(s == 1));
      check("l1_enable", acc_enable1, int'(s == 3));
      check("l1_res_valid", res_valid1, int'(s == 5));
      check("l1_busy", busy1, int'(s <= 4));
      if (s == 3) check("l1_din", int'(acc_din1), 16'h0600);
      if (s == 5) check("l1_res", int'(res1), 16'h0680);
    end

    for (int t = 0; t < 50 && (clr_q.size() + din_q.size() + res_q.size()) != 0; t++) step();
    check("queues_drained", clr_q.size() + din_q.size() + res_q.size(), 0);
    repeat (10) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
